// File: rtl/state_fork_fifo_if.sv
// Handshake bundle for the state fork FIFO: one upstream producer port and
// NCH downstream consumer channels sharing a single data word.
interface state_fork_fifo_if #(
    parameter int NN  = 6,
    parameter int WF  = 8,
    parameter int NCH = 2
);
    logic                 iValid_AM_State;
    logic                 oReady_AM_State;
    logic [NN*WF-1:0]     iData_AM_State;
    logic [NCH-1:0]       oValid_BM_State;
    logic [NCH-1:0]       iReady_BM_State;
    logic [NN*WF-1:0]     oData_BM_State;

    // Environment side: drives upstream data and downstream readies
    modport master (
        output iValid_AM_State,
        output iData_AM_State,
        output iReady_BM_State,
        input  oReady_AM_State,
        input  oValid_BM_State,
        input  oData_BM_State
    );

    // FIFO side
    modport slave (
        input  iValid_AM_State,
        input  iData_AM_State,
        input  iReady_BM_State,
        output oReady_AM_State,
        output oValid_BM_State,
        output oData_BM_State
    );
endinterface

// File: rtl/state_fork_fifo.sv
// Inter-layer state channel: DEPTH-entry FIFO whose head is forked to NCH
// consumers. An entry retires once every channel its mode requires has
// taken it; channels already served wait (valid low) for the next head.
module state_fork_fifo #(
    parameter int NN    = 6,
    parameter int WF    = 8,
    parameter int DEPTH = 4,
    parameter int NCH   = 2
) (
    input  logic                        iCLK,
    input  logic                        iRST,
    input  logic                        iMode,
    state_fork_fifo_if.slave            bus,
    output logic [$clog2(DEPTH+1)-1:0]  oCount
);
    localparam int DW = NN * WF;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0]  r_mem      [DEPTH];
    logic           r_mode_mem [DEPTH];
    logic [PW-1:0]  r_wr;
    logic [PW-1:0]  r_rd;
    logic [CW-1:0]  r_count;
    logic [NCH-1:0] r_tk;
    logic [DW-1:0]  r_data;

    logic           w_empty;
    logic           w_full;
    logic           w_push;
    logic           w_retire;
    logic [NCH-1:0] w_req;
    logic [NCH-1:0] w_valid;
    logic [NCH-1:0] w_fire;
    logic [PW-1:0]  w_rd_nxt;
    logic [DW-1:0]  w_head_nxt;

    // Pointer advance with wrap from DEPTH-1 back to 0 (DEPTH need not be 2^n)
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PW'(DEPTH - 1)) begin
            n = {PW{1'b0}};
        end else begin
            n = p + PW'(1);
        end
        return n;
    endfunction

    assign w_empty = (r_count == {CW{1'b0}});
    assign w_full  = (r_count == CW'(DEPTH));

    // Upstream ready depends only on occupancy, never on downstream readies
    assign bus.oReady_AM_State = ~w_full & ~iRST;
    assign w_push              = bus.iValid_AM_State & bus.oReady_AM_State;

    // Required-channel mask of the head: training needs all, inference ch0 only
    always_comb begin
        w_req = {NCH{1'b0}};
        if (r_mode_mem[r_rd]) begin
            w_req = {NCH{1'b1}};
        end else begin
            w_req[0] = 1'b1;
        end
    end

    assign w_valid  = {NCH{~w_empty}} & w_req & ~r_tk;
    assign w_fire   = w_valid & bus.iReady_BM_State;
    assign w_retire = ~w_empty & (((r_tk | w_fire) & w_req) == w_req);

    assign bus.oValid_BM_State = w_valid;
    assign bus.oData_BM_State  = r_data;
    assign oCount              = r_count;

    // Next head word: a push landing in the slot that becomes head shows up directly
    always_comb begin
        w_rd_nxt   = r_rd;
        w_head_nxt = r_mem[r_rd];
        if (w_retire) begin
            w_rd_nxt = ptr_inc(r_rd);
        end else begin
            w_rd_nxt = r_rd;
        end
        if (w_push && (w_rd_nxt == r_wr)) begin
            w_head_nxt = bus.iData_AM_State;
        end else begin
            w_head_nxt = r_mem[w_rd_nxt];
        end
    end

    // Entry storage: data word plus the mode captured at push time
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i]      <= {DW{1'b0}};
                r_mode_mem[i] <= 1'b0;
            end
        end else if (w_push) begin
            r_mem[r_wr]      <= bus.iData_AM_State;
            r_mode_mem[r_wr] <= iMode;
        end
    end

    // Pointers, occupancy, taken flags and the head output register
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_wr    <= {PW{1'b0}};
            r_rd    <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
            r_tk    <= {NCH{1'b0}};
            r_data  <= {DW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr <= ptr_inc(r_wr);
            end
            r_rd   <= w_rd_nxt;
            r_data <= w_head_nxt;
            case ({w_push, w_retire})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_retire) begin
                r_tk <= {NCH{1'b0}};
            end else begin
                r_tk <= r_tk | w_fire;
            end
        end
    end
endmodule

// File: tb/tb_state_fork_fifo.sv
// Directed bench for state_fork_fifo (NN=6, WF=8, DEPTH=4, NCH=2).
// Each table row gives the inputs driven for one cycle and the outputs
// expected in that cycle, before the following rising edge.
module tb_state_fork_fifo;
    logic       clk;
    logic       rst;
    logic       mode;
    logic [2:0] count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        mode;
        logic        valid;
        logic [47:0] data;
        logic [1:0]  rdy;
        logic [1:0]  ev;
        logic [47:0] ed;
        logic [2:0]  ec;
        logic        er;
        logic        chkd;
    } vec_t;

    vec_t tbl[$];

    state_fork_fifo_if #(.NN(6), .WF(8), .NCH(2)) bus_if ();

    state_fork_fifo #(.NN(6), .WF(8), .DEPTH(4), .NCH(2)) dut (
        .iCLK   (clk),
        .iRST   (rst),
        .iMode  (mode),
        .bus    (bus_if),
        .oCount (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int m, input int v, input int d, input int r,
                       input int ev, input int ed, input int ec, input int er, input int chkd);
        vec_t t;
        t.mode  = m[0];
        t.valid = v[0];
        t.data  = 48'(d);
        t.rdy   = r[1:0];
        t.ev    = ev[1:0];
        t.ed    = 48'(ed);
        t.ec    = ec[2:0];
        t.er    = er[0];
        t.chkd  = chkd[0];
        tbl.push_back(t);
    endtask

    task automatic drive(input logic m, input logic v, input logic [47:0] d, input logic [1:0] r);
        mode                   = m;
        bus_if.iValid_AM_State = v;
        bus_if.iData_AM_State  = d;
        bus_if.iReady_BM_State = r;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] ev, input logic [2:0] ec, input logic er);
        check({tag, ".valid"}, 64'(bus_if.oValid_BM_State), 64'(ev));
        check({tag, ".count"}, 64'(count), 64'(ec));
        check({tag, ".ready"}, 64'(bus_if.oReady_AM_State), 64'(er));
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 48'h0, 2'b00);

        // Pass-through: training mode, both readies high, 0x01..0x08
        add(1, 1, 1, 3, 0, 0, 0, 1, 0);
        for (int k = 2; k <= 8; k++) add(1, 1, k, 3, 3, k - 1, 1, 1, 1);
        add(1, 0, 0, 3, 3, 8, 1, 1, 1);
        add(1, 0, 0, 3, 0, 0, 0, 1, 0);

        // Inference mask: ch1 never ready, three mode-0 words, then one mode-1 word
        add(0, 1, 'h11, 1, 0, 0, 0, 1, 0);
        add(0, 1, 'h12, 1, 1, 'h11, 1, 1, 1);
        add(0, 1, 'h13, 1, 1, 'h12, 1, 1, 1);
        add(1, 1, 'h14, 1, 1, 'h13, 1, 1, 1);
        add(0, 0, 0, 1, 3, 'h14, 1, 1, 1);
        add(0, 0, 0, 0, 2, 'h14, 1, 1, 1);
        add(0, 0, 0, 2, 2, 'h14, 1, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Staggered fork: A taken by ch0 first, by ch1 two cycles later
        add(1, 1, 'h31, 0, 0, 0, 0, 1, 0);
        add(1, 1, 'h32, 0, 3, 'h31, 1, 1, 1);
        add(1, 0, 0, 1, 3, 'h31, 2, 1, 1);
        add(1, 0, 0, 0, 2, 'h31, 2, 1, 1);
        add(1, 0, 0, 2, 2, 'h31, 2, 1, 1);
        add(1, 0, 0, 0, 3, 'h32, 1, 1, 1);
        add(1, 0, 0, 3, 3, 'h32, 1, 1, 1);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0);

        // Full and wrap: readies low, offer 6 words, only 4 fit
        add(1, 1, 'h21, 0, 0, 0, 0, 1, 0);
        add(1, 1, 'h22, 0, 3, 'h21, 1, 1, 1);
        add(1, 1, 'h23, 0, 3, 'h21, 2, 1, 1);
        add(1, 1, 'h24, 0, 3, 'h21, 3, 1, 1);
        add(1, 1, 'h25, 0, 3, 'h21, 4, 0, 1);
        add(1, 1, 'h25, 0, 3, 'h21, 4, 0, 1);
        // Full plus retire: 0x25 rejected while 0x21 retires, accepted next cycle
        add(1, 1, 'h25, 3, 3, 'h21, 4, 0, 1);
        for (int k = 0; k < 10; k++) add(1, 1, 'h25 + k, 3, 3, 'h22 + k, 3, 1, 1);
        add(1, 0, 0, 3, 3, 'h2c, 3, 1, 1);
        add(1, 0, 0, 3, 3, 'h2d, 2, 1, 1);
        add(1, 0, 0, 3, 3, 'h2e, 1, 1, 1);
        add(1, 0, 0, 3, 0, 0, 0, 1, 0);

        // Reset state
        #2;
        check_outs("reset", 2'b00, 3'd0, 1'b0);
        check("reset.data", 64'(bus_if.oData_BM_State), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].mode, tbl[i].valid, tbl[i].data, tbl[i].rdy);
            #1;
            check_outs($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ec, tbl[i].er);
            if (tbl[i].chkd) begin
                check($sformatf("vec%0d.data", i), 64'(bus_if.oData_BM_State), 64'(tbl[i].ed));
            end
        end

        // Reset mid-operation: 3 entries held, ch0 already took the head
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 48'h51 + 48'(k), 2'b00);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 48'h0, 2'b01);
        #1;
        check_outs("pre_rst_a", 2'b11, 3'd3, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b0, 48'h0, 2'b00);
        #1;
        check_outs("pre_rst_b", 2'b10, 3'd3, 1'b1);
        check("pre_rst_b.data", 64'(bus_if.oData_BM_State), 64'h51);
        #2;
        rst = 1'b1;
        #1;
        check_outs("mid_rst", 2'b00, 3'd0, 1'b0);
        check("mid_rst.data", 64'(bus_if.oData_BM_State), 64'h0);
        @(posedge clk);
        #1;
        check_outs("mid_rst_edge", 2'b00, 3'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outs("post_rst", 2'b00, 3'd0, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b1, 48'h41, 2'b00);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 48'h0, 2'b00);
        #1;
        check_outs("fresh", 2'b11, 3'd1, 1'b1);
        check("fresh.data", 64'(bus_if.oData_BM_State), 64'h41);
        @(negedge clk);
        drive(1'b1, 1'b0, 48'h0, 2'b11);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 48'h0, 2'b00);
        #1;
        check_outs("fresh_retired", 2'b00, 3'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/state_fork_fifo.md
# state_fork_fifo

Parametrised inter-layer state channel for the next-generation network. It buffers layer state vectors in a DEPTH-entry FIFO and forks each entry to NCH consumers, each with its own valid/ready handshake. An entry retires only when every consumer required by its mode has accepted it. It replaces the direct State0/State1 wire pairs between InputLayer, HiddenLayer and OutputLayer. Consumers may back-pressure independently without stalling each other's accepted beats.

## Interface
- NN, 6, neurons per state vector
- WF, 8, bits per neuron value
- DEPTH, 4, FIFO entries (≥2, any integer)
- NCH, 2, fork channels; channel 0 is the forward path, channels 1..NCH-1 are the training paths
- iCLK  in  1  clock, all state on rising edge
- iRST  in  1  reset, asynchronous, active-high
- iMode  in  1  1 = training, 0 = inference; sampled per entry at enqueue
- iValid_AM_State  in  1  upstream valid
- oReady_AM_State  out  1  upstream ready
- iData_AM_State  in  NN*WF  upstream state vector
- oValid_BM_State  out  NCH  per-channel valid
- iReady_BM_State  in  NCH  per-channel ready
- oData_BM_State  out  NN*WF  head entry, shared by all channels
- oCount  out  $clog2(DEPTH+1)  entries held

## Operation
- Storage:
  - Each entry holds the data word and a mode bit (iMode captured at push).
  - Write and read pointers wrap from DEPTH-1 to 0.
- Push: iValid_AM_State & oReady_AM_State.
- Required mask of the head entry:
  - mode bit 1: all NCH channels required.
  - mode bit 0: only channel 0 required.
- Per-channel taken flags tk[NCH] apply to the head entry only.
- Outputs:
  - oValid_BM_State[c] = ~empty & req[c] & ~tk[c].
  - Beat on channel c: fire[c] = oValid_BM_State[c] & iReady_BM_State[c].
- Retire: head retires when, for every c with req[c]=1, tk[c] | fire[c] holds.
  - On retire: pop, clear tk to 0.
  - Otherwise: tk |= fire.
- Unrequired channels never assert valid, and their iReady is ignored.
- Backpressure:
  - oReady_AM_State = (oCount < DEPTH) & ~iRST.
  - No combinational path from iReady_BM_State to oReady_AM_State. A full FIFO rejects a push even in a cycle that retires.
- Simultaneous push and retire when not full: count unchanged, both pointers advance.
- oCount: +1 on push only, −1 on retire only, unchanged on both or neither.
- iMode changes never affect entries already stored.
- Reset (asynchronous, any time):
  - Pointers, oCount and tk go to 0. All stored entries are discarded.
  - oData_BM_State reads 0, because storage and the output register reset to 0.
  - oValid_BM_State = 0.
  - oReady_AM_State = 0 while iRST is high, and 1 from the first edge after release.

## Timing
- Latency:
  - A push into an empty FIFO at edge t drives oValid/oData from just after edge t.
  - No same-cycle bypass from input to output.
- Throughput:
  - One entry per cycle when all required readies are held high.
  - An entry accepted on different channels in different cycles retires in the cycle its last required beat fires.
- Hold rule:
  - oData_BM_State is stable while any oValid_BM_State bit is high and the head has not retired.
  - A channel's valid drops the cycle after its beat fires and stays low until the next head.
- Empty: all oValid bits low; oData holds its last value (don't-care).

## Test plan
- **Pass-through.** DEPTH=4, NCH=2, iMode=1, both readies high, push 0x01..0x08 back-to-back.
  - Required: each word appears on both channels in order, 1-cycle latency, oCount never exceeds 1.
- **Staggered fork.** Push A and B.
  - Cycle 1: ready[0]=1 only; ch0 takes A, oValid[0] drops.
  - Cycle 3: ready[1]=1.
  - Required: A retires in cycle 3, B becomes head, oValid=2'b11.
- **Inference mask.** iMode=0, ready[1]=0 forever, push 3 words.
  - Required: all 3 retire via ch0 alone; oValid[1] never asserts.
  - Then push 1 word with iMode=1: oValid[1] asserts for it only.
- **Full/wrap.** Hold readies low and push 6 words.
  - Required: oReady_AM_State drops after the 4th push, oCount=4.
  - Release the readies and continue pushing 10 more words.
  - Required: order preserved across pointer wrap, no loss or duplication.
- **Reset mid-operation.** Assert iRST mid-cycle with 3 entries held and tk=2'b01.
  - Required: oValid immediately 0, oCount=0, oReady 0 during reset.
  - After release: a fresh push appears with tk clear on both channels.
- **Full plus retire.** Full FIFO, head retires while upstream is valid.
  - Required: push rejected that cycle, oCount=3, push accepted next cycle.
